// File: rtl/semaforo_driver_pkg.sv
// Shared types for the signal-head lamp driver: aspect states and {r,y,g} lamp vectors.
package semaforo_driver_pkg;

    typedef enum logic [2:0] {
        ST_RED    = 3'd0,
        ST_GREEN  = 3'd1,
        ST_YELLOW = 3'd2,
        ST_BLINK  = 3'd3,
        ST_FLASH  = 3'd4
    } state_t;

    typedef struct packed {
        logic r;
        logic y;
        logic g;
    } lamp_t;

    localparam lamp_t LAMP_RED    = lamp_t'(3'b100);
    localparam lamp_t LAMP_YELLOW = lamp_t'(3'b010);
    localparam lamp_t LAMP_GREEN  = lamp_t'(3'b001);
    localparam lamp_t LAMP_OFF    = lamp_t'(3'b000);

    // Pedestrian clearance: only the green lamp is ever lit.
    function automatic lamp_t blink_lamp(input logic green_on);
        lamp_t l;
        l   = LAMP_OFF;
        l.g = green_on;
        return l;
    endfunction

endpackage

// File: rtl/semaforo_driver_if.sv
// Handshake between the intersection sequencing FSM (master) and one lamp driver (slave).
interface semaforo_driver_if;
    logic enable_general;
    logic change;
    logic load;
    logic set_value;
    logic lamp_red;
    logic lamp_yellow;
    logic lamp_green;
    logic red_check;
    logic busy;

    modport master (
        output enable_general, change, load, set_value,
        input  lamp_red, lamp_yellow, lamp_green, red_check, busy
    );

    modport slave (
        input  enable_general, change, load, set_value,
        output lamp_red, lamp_yellow, lamp_green, red_check, busy
    );
endinterface

// File: rtl/semaforo_driver_blink_timer.sv
// Half-period timer: counts HALF_CYCLES clocks and flags the last one with a one-cycle tick.
module blink_timer #(
    parameter int unsigned HALF_CYCLES = 2500
) (
    input  logic CLK,
    input  logic reset_general,
    input  logic clr,
    input  logic en,
    output logic tick_c
);
    localparam int unsigned CNT_W = (HALF_CYCLES > 1) ? $clog2(HALF_CYCLES) : 1;

    logic [CNT_W-1:0] cnt_q;

    assign tick_c = en && !clr && (cnt_q == CNT_W'(HALF_CYCLES - 1));

    always_ff @(posedge CLK) begin
        if (reset_general) begin
            cnt_q <= '0;
        end else if (clr) begin
            cnt_q <= '0;
        end else if (en) begin
            cnt_q <= tick_c ? '0 : cnt_q + CNT_W'(1);
        end
    end
endmodule

// File: rtl/semaforo_driver.sv
// Lamp driver for one vehicle or pedestrian signal head.
// Optional SEMAFORO_FLASH_EN: out-of-service flashing instead of steady red.
module semaforo_driver
    import semaforo_driver_pkg::*;
#(
    parameter int unsigned PEATON            = 0,
    parameter int unsigned BLINK_HALF_CYCLES = 2500,
    parameter int unsigned BLINK_PHASES      = 6
) (
    input  logic               CLK,
    input  logic               reset_general,
    semaforo_driver_if.slave   bus
);
    localparam int unsigned PH_W = $clog2(BLINK_PHASES + 1);

    state_t          state_q, state_n;
    logic [PH_W-1:0] phase_q, phase_n;
    logic            change_q, change_n;
    lamp_t           lamp_q, lamp_n;
    logic            red_check_q, busy_q;
    logic            adv_c, tmr_clr_c, tmr_en_c, tick_c;
`ifdef SEMAFORO_FLASH_EN
    logic            flash_q, flash_n;
`endif

    assign adv_c = bus.change && !change_q;

    // Timer control kept apart from next-state logic so tick_c never feeds back into itself.
    always_comb begin
        tmr_en_c  = 1'b1;
        tmr_clr_c = (state_q != ST_BLINK);
        if (!bus.enable_general) begin
`ifdef SEMAFORO_FLASH_EN
            tmr_clr_c = (state_q != ST_FLASH);
`else
            tmr_en_c  = 1'b0;
            tmr_clr_c = 1'b0;
`endif
        end else if (bus.load) begin
            tmr_clr_c = 1'b1;
        end
    end

    blink_timer #(
        .HALF_CYCLES (BLINK_HALF_CYCLES)
    ) u_blink_timer (
        .CLK           (CLK),
        .reset_general (reset_general),
        .clr           (tmr_clr_c),
        .en            (tmr_en_c),
        .tick_c        (tick_c)
    );

    // Next state and next lamp image; outputs are registered from these.
    always_comb begin
        state_n  = state_q;
        phase_n  = phase_q;
        change_n = bus.change;
        lamp_n   = LAMP_RED;
`ifdef SEMAFORO_FLASH_EN
        flash_n  = flash_q;
`endif

        if (!bus.enable_general) begin
`ifdef SEMAFORO_FLASH_EN
            state_n = ST_FLASH;
            phase_n = '0;
            flash_n = (state_q != ST_FLASH) ? 1'b1 : (flash_q ^ tick_c);
`else
            change_n = change_q;
`endif
        end else if (bus.load) begin
            state_n = bus.set_value ? ST_RED : ST_GREEN;
            phase_n = '0;
        end else begin
            case (state_q)
                ST_RED:    if (adv_c) state_n = ST_GREEN;
                ST_GREEN: begin
                    if (adv_c) begin
                        state_n = (PEATON != 0) ? ST_BLINK : ST_YELLOW;
                        phase_n = '0;
                    end
                end
                ST_YELLOW: if (adv_c) state_n = ST_RED;
                ST_BLINK: begin
                    if (tick_c) begin
                        if (phase_q == PH_W'(BLINK_PHASES - 1)) begin
                            state_n = ST_RED;
                            phase_n = '0;
                        end else begin
                            phase_n = phase_q + PH_W'(1);
                        end
                    end
                end
                default: begin
                    state_n = ST_RED;
                    phase_n = '0;
                end
            endcase
        end

        case (state_n)
            ST_RED:    lamp_n = LAMP_RED;
            ST_GREEN:  lamp_n = LAMP_GREEN;
            ST_YELLOW: lamp_n = (PEATON != 0) ? LAMP_OFF : LAMP_YELLOW;
            ST_BLINK:  lamp_n = blink_lamp(phase_n[0]);
`ifdef SEMAFORO_FLASH_EN
            ST_FLASH: begin
                lamp_n   = LAMP_OFF;
                lamp_n.y = (PEATON == 0) && flash_n;
            end
`endif
            default:   lamp_n = LAMP_RED;
        endcase

`ifndef SEMAFORO_FLASH_EN
        if (!bus.enable_general) lamp_n = LAMP_RED;
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset_general) begin
            state_q     <= ST_RED;
            phase_q     <= '0;
            change_q    <= 1'b0;
            lamp_q      <= LAMP_RED;
            red_check_q <= 1'b1;
            busy_q      <= 1'b0;
`ifdef SEMAFORO_FLASH_EN
            flash_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_n;
            phase_q     <= phase_n;
            change_q    <= change_n;
            lamp_q      <= lamp_n;
            red_check_q <= (state_n == ST_RED) && bus.enable_general;
            busy_q      <= (state_n == ST_BLINK);
`ifdef SEMAFORO_FLASH_EN
            flash_q     <= flash_n;
`endif
        end
    end

    assign bus.lamp_red    = lamp_q.r;
    assign bus.lamp_yellow = lamp_q.y;
    assign bus.lamp_green  = lamp_q.g;
    assign bus.red_check   = red_check_q;
    assign bus.busy        = busy_q;

endmodule

// File: doc/semaforo_driver.md
# semaforo_driver

Per-signal-head lamp driver sitting directly downstream of the intersection sequencing FSM. It consumes one change pulse and the matching set/load pair from the FSM, holds the current aspect of one signal head, and drives the red/yellow/green lamp outputs. It returns a red-status flag to the FSM. The FSM instantiates one driver per vehicle head (NN, NS, TH, turn arrows) and per pedestrian head (peaton N, TH1, TH2).

## Interface
- PEATON, 0: 0 = vehicle head (R/Y/G); 1 = pedestrian head (R/G, blinking green before red)
- BLINK_HALF_CYCLES, 2500: CLK cycles per blink half-period (0.25 s at 10 kHz); ≥2
- BLINK_PHASES, 6: blink half-periods in pedestrian clearance; even, ≥2
- CLK  in  1  10 kHz system clock
- reset_general  in  1  synchronous reset, active-high
- enable_general  in  1  global enable; low = out-of-service mode
- change  in  1  advance request from FSM; rising-edge detected
- load  in  1  force aspect from set_value (FSM reset/set state)
- set_value  in  1  aspect for load: 1 = RED, 0 = GREEN
- lamp_red, lamp_yellow, lamp_green  out  1 each  registered lamp drives
- red_check  out  1  high while the aspect is steady RED
- busy  out  1  high during pedestrian blink clearance

## Operation
- States: RED, GREEN, YELLOW (vehicle only), BLINK (pedestrian only), FLASH (only with macro).
- Edge detect: change_q registered each cycle. Advance when change=1 and change_q=0. A level held high advances once.
- Vehicle: RED→GREEN→YELLOW→RED, one step per advance.
- Pedestrian: RED→GREEN→BLINK. BLINK exits to RED automatically after BLINK_PHASES half-periods. Advances during BLINK are ignored.
- BLINK: green lamp off in the first half-period, then toggles every BLINK_HALF_CYCLES cycles. The sequence is off,on,…,on, then RED. Total duration is BLINK_PHASES×BLINK_HALF_CYCLES cycles.
- load=1: state set to RED (set_value=1) or GREEN (set_value=0). The blink counters clear and any edge on change that cycle is discarded.
- Priority per cycle: reset_general > enable_general low > load > advance > blink timeout.
- enable_general low: behaviour per Configuration. State, counters and change_q are retained only in the non-macro build. Returning high resumes at the retained state (non-macro) or at RED (macro).
- Outputs are one-hot among lit lamps. Yellow is never lit when PEATON=1.
- red_check = (state==RED) and enable_general. It is 0 during BLINK and FLASH.
- busy = (state==BLINK).

## Timing
- Reset values: state RED, lamp_red=1, lamp_yellow=0, lamp_green=0, red_check=1, busy=0, counters 0, change_q=0.
- Latency: an advance or load sampled at edge n shows on the lamps from edge n (all outputs registered from next-state). The new aspect is visible in cycle n+1.
- Back-to-back change pulses need a low cycle between them. Vehicle minimum full cycle is 6 CLK cycles.
- Blink counter width is $clog2(BLINK_HALF_CYCLES). It wraps to 0 on each half-period tick. The phase counter width is $clog2(BLINK_PHASES+1).
- Reset mid-BLINK: RED next cycle, counters cleared.
- load mid-BLINK: takes effect immediately. BLINK is abandoned.

## Configuration
- SEMAFORO_FLASH_EN defined: enable_general low → FLASH. Vehicle heads blink yellow using the same half-period timer, starting lit. Pedestrian heads are all dark. On enable return, the state goes to RED and the counters clear.
- Undefined: enable_general low forces lamp_red=1 with other lamps off, and freezes state and counters. There is no FLASH state.

## Structure
- semaforo_pkg: state enum (RED, GREEN, YELLOW, BLINK, FLASH) and lamp-vector constants (3-bit {r,y,g} per aspect).
- Sub-module blink_timer: counts BLINK_HALF_CYCLES and emits a one-cycle tick. It has a clear input and is shared by BLINK and FLASH.

## Test plan
- Vehicle: reset, then three change pulses 1 cycle wide separated by 10 cycles → lamps 100→001→010→100. red_check is 0 between the first and third pulse.
- Pedestrian (BLINK_HALF_CYCLES=4, BLINK_PHASES=6): two pulses → green, then green 0,1,0,1,0,1 for 4 cycles each. RED appears exactly 24 cycles after the second advance. busy is high for those 24 cycles. A pulse mid-blink is ignored.
- change held high for 50 cycles → exactly one advance.
- load with set_value=0 and a simultaneous change edge from RED → GREEN only, no further advance. load with set_value=1 mid-BLINK → RED next cycle, busy=0.
- reset_general asserted while in YELLOW → lamps 100, red_check=1 the next cycle.
- enable_general low for 20 cycles in GREEN: without macro, lamps 100 with state held, and green returns on re-enable. With SEMAFORO_FLASH_EN (HALF=4), yellow toggles every 4 cycles, and the head is RED on re-enable.
